// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - synchronous LIFO stack with registered pop data and empty/full flags
//
// Purpose: DEPTH x WIDTH register-array stack. A push stores data_in on top,
// a pop moves the top word onto the registered data_out, and a simultaneous
// read+write on a non-empty stack exchanges the top word with data_in.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset (pointer, flags, data_out, memory)
//   write     in   1      push request
//   read      in   1      pop request
//   data_in   in   WIDTH  word to push
//   address   in   8      reserved, ignored
//   empty     out  1      stack holds no entries
//   full      out  1      stack holds DEPTH entries
//   data_out  out  WIDTH  last popped word (registered)

module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data_in,
  input  logic [7:0]       address,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] data_out
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             push_ok;
  logic             pop_ok;
  logic             xchg_ok;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [SPW-1:0]   sp_m1;
  logic [PW-1:0]    top_idx;

  // The reserved address bus is intentionally left unconnected to any logic.
  logic unused_address;
  assign unused_address = ^address;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SPW'(DEPTH));
  assign data_out = dout_q;

  assign sp_m1   = sp_q - SPW'(1);
  assign top_idx = sp_m1[PW-1:0];

  // A read+write on an empty stack degrades to a plain push; on a non-empty
  // stack (including full) it is an exchange that leaves sp unchanged.
  assign xchg_ok = read && write && !empty;
  assign push_ok = write && (!read || empty) && !full;
  assign pop_ok  = read && !write && !empty;

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[PW-1:0];
    if (xchg_ok) begin
      dout_d = mem_q[top_idx];
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_ok) begin
      wr_en  = 1'b1;
      wr_idx = sp_q[PW-1:0];
      sp_d   = sp_q + SPW'(1);
    end else if (pop_ok) begin
      dout_d = mem_q[top_idx];
      sp_d   = sp_m1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack with a queue-based reference model

module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [7:0]       address = 'x;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] data_out;

  int total = 0;
  int bad = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_dout = '0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .write(write),
    .read(read),
    .data_in(data_in),
    .address(address),
    .empty(empty),
    .full(full),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk.delete();
      m_dout = '0;
    end else if (read && write && stk.size() > 0) begin
      m_dout = stk[stk.size()-1];
      stk[stk.size()-1] = data_in;
    end else if (write) begin
      if (stk.size() < DEPTH) stk.push_back(data_in);
    end else if (read) begin
      if (stk.size() > 0) m_dout = stk.pop_back();
    end
  end

  always @(negedge clk) begin
    check("no_x_outputs", int'($isunknown({empty, full, data_out})), 0);
    check("model_empty", int'(empty), int'(stk.size() == 0));
    check("model_full", int'(full), int'(stk.size() == DEPTH));
    check("model_data_out", int'(data_out), int'(m_dout));
  end

  // Drive one request; returns at the following negedge with outputs settled.
  task automatic op(input logic w, input logic r, input logic [WIDTH-1:0] d);
    write = w;
    read = r;
    data_in = d;
    @(negedge clk);
    write = 1'b0;
    read = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] pushes[8];
    logic [WIDTH-1:0] pops[10];
    pushes = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd16, 8'd18};
    pops   = '{8'd18, 8'd16, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2, 8'd2, 8'd2};

    // Reset held for 1000 ns with request pulses that must be ignored.
    @(negedge clk);
    for (int i = 0; i < 99; i++) begin
      write = i[0];
      read = i[1];
      data_in = 8'(i);
      @(negedge clk);
    end
    write = 1'b0;
    read = 1'b0;
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_data_out", int'(data_out), 0);
    reset = 1'b0;

    // Fill the stack.
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, pushes[i]);
      if (i == 0) check("empty_after_first_push", int'(empty), 0);
    end
    check("full_after_eight", int'(full), 1);
    check("data_out_after_fill", int'(data_out), 0);

    // Push while full is dropped; the next pop still returns the old top.
    op(1'b1, 1'b0, 8'd99);
    check("full_push_ignored_full", int'(full), 1);
    op(1'b0, 1'b1, 8'd0);
    check("pop_after_full_push", int'(data_out), 18);
    check("not_full_after_pop", int'(full), 0);
    op(1'b1, 1'b0, 8'd18);
    check("refilled", int'(full), 1);

    // Ten consecutive pops from full; the last two underflow harmlessly.
    read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pop_seq_data", int'(data_out), int'(pops[i]));
      check("pop_seq_empty", int'(empty), int'(i >= 7));
    end
    read = 1'b0;

    // Exchange on a two-entry stack.
    op(1'b1, 1'b0, 8'd5);
    op(1'b1, 1'b0, 8'd7);
    op(1'b1, 1'b1, 8'd9);
    check("xchg_data_out", int'(data_out), 7);
    check("xchg_count", stk.size(), 2);
    op(1'b0, 1'b1, 8'd0);
    check("after_xchg_pop1", int'(data_out), 9);
    op(1'b0, 1'b1, 8'd0);
    check("after_xchg_pop2", int'(data_out), 5);
    check("after_xchg_empty", int'(empty), 1);

    // Read+write on empty behaves as a plain push.
    op(1'b1, 1'b1, 8'd33);
    check("rw_empty_push_data_out", int'(data_out), 5);
    op(1'b0, 1'b1, 8'd0);
    check("rw_empty_push_pop", int'(data_out), 33);

    // Randomized phases biased toward filling, draining and mixing.
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 55;
      pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 55;
      for (int i = 0; i < 500; i++) begin
        op(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
      end
    end

    // Asynchronous reset between edges after three pushes.
    op(1'b1, 1'b0, 8'd41);
    op(1'b1, 1'b0, 8'd42);
    op(1'b1, 1'b0, 8'd43);
    op(1'b0, 1'b1, 8'd0);
    check("pre_async_data_out", int'(data_out), 43);
    #2;
    reset = 1'b1;
    #1;
    check("async_empty", int'(empty), 1);
    check("async_full", int'(full), 0);
    check("async_data_out", int'(data_out), 0);
    @(negedge clk);
    reset = 1'b0;
    op(1'b1, 1'b0, 8'd77);
    op(1'b0, 1'b1, 8'd0);
    check("post_reset_first_edge_push", int'(data_out), 77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

- Synchronous last-in-first-out stack: 8-bit words, default depth 8.
- Pushes on `write`, pops on `read`, and presents the popped word on a registered `data_out`.
- Exposes `empty`/`full` status flags.
- Used as a small local buffer between a byte producer and a consumer that needs reverse-order retrieval.

## Interface
Parameters:
- WIDTH, 8, data word width (`data_in`/`data_out`).
- DEPTH, 8, number of stack entries; power of two, 2..256.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears pointer, flags, `data_out`.
- write  in  1  push request, sampled at rising edge.
- read  in  1  pop request, sampled at rising edge.
- data_in  in  WIDTH  word to push.
- address  in  8  reserved; ignored by the block. May be undriven/X; must not affect any output.
- empty  out  1  high when stack holds 0 entries.
- full  out  1  high when stack holds DEPTH entries.
- data_out  out  WIDTH  last popped word (registered).

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer `sp`, range 0..DEPTH, width clog2(DEPTH)+1. `sp` = number of valid entries.
- empty = (sp == 0); full = (sp == DEPTH). Decoded from `sp` only.
- Push (write=1, read=0, full=0): mem[sp] <= data_in; sp <= sp+1.
- Pop (read=1, write=0, empty=0): data_out <= mem[sp-1]; sp <= sp-1.
- Write with full=1: ignored. No memory change, sp unchanged, no error flag.
- Read with empty=1: ignored. data_out holds its previous value; sp stays 0 (no underflow wrap).
- Simultaneous read and write:
  - empty=0: exchange. data_out <= mem[sp-1]; mem[sp-1] <= data_in; sp unchanged. Valid also when full.
  - empty=1: plain push.
- data_out changes only on a successful pop/exchange or reset; otherwise holds.
- Reset: sp=0, data_out=0, empty=1, full=0. Memory array is also cleared to 0.

## Timing
- Push/pop take effect at the sampling rising edge; one operation per cycle, back-to-back allowed every cycle.
- empty/full reflect the new sp immediately after the edge (same-cycle flag latency as the pointer).
- Pop latency: popped word appears on data_out one edge after the request is sampled, i.e. valid in the following cycle.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous), independent of clk.
- Requests sampled on the first rising edge after reset deassertion are honored.
- No handshake or ready signal; the requester must observe full/empty to avoid dropped operations.

## Test plan
- Reset held 1000 ns → empty=1, full=0, data_out=0; write/read pulses during reset have no effect.
- Push 2,4,6,8,10,12,16,18 on 8 consecutive edges → empty=0 after first edge; full=1 after eighth edge; data_out stays 0.
- From full, hold read for 10 cycles → data_out sequence 18,16,12,10,8,6,4,2; empty=1 after the eighth pop. Pops 9–10 leave data_out=2 and empty=1.
- From full, push 99 → ignored; subsequent single pop returns 18, full=0.
- With stack holding 5,7, assert read and write with data_in=9 → data_out=7, count stays 2; next pop returns 9, then 5.
- Push 3 values, assert reset asynchronously between clock edges → empty=1, full=0, data_out=0 at once; address driven X throughout causes no X on any output.
